// File: rtl/crc_stream_engine_if.sv
// Request/result bundle for crc_stream_engine.
// The producer side (frame packer / deframer) uses the master modport and
// the engine uses the slave modport.
interface crc_stream_engine_if #(
    parameter int DATAWIDTH = 10,
    parameter int CRCWIDTH  = 4
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic                 mode;
    logic [DATAWIDTH-1:0] datain;
    logic [CRCWIDTH-1:0]  crcin;
    logic [CRCWIDTH:0]    genPoly;
    logic                 out_valid;
    logic                 out_ready;
    logic [CRCWIDTH-1:0]  crcSeq;
    logic                 crc_ok;

    modport master (
        output in_valid, mode, datain, crcin, genPoly, out_ready,
        input  in_ready, out_valid, crcSeq, crc_ok
    );

    modport slave (
        input  in_valid, mode, datain, crcin, genPoly, out_ready,
        output in_ready, out_valid, crcSeq, crc_ok
    );
endinterface

// File: rtl/crc_stream_engine.sv
// Multi-bit-per-cycle CRC engine with a runtime generator polynomial.
// Divides a DATAWIDTH-bit message (MSB first, augmented with CRCWIDTH zeros)
// by the generator, BPC bits per clock, and either returns the CRC (ENCODE)
// or compares it against a received CRC (CHECK).
module crc_stream_engine #(
    parameter int                  DATAWIDTH = 10,
    parameter int                  CRCWIDTH  = 4,
    parameter int                  BPC       = 1,
    parameter logic [CRCWIDTH-1:0] INIT      = '0,
    parameter logic [CRCWIDTH-1:0] XOROUT    = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    crc_stream_engine_if.slave   bus
);
    localparam int NCYC = DATAWIDTH / BPC;
    localparam int CNTW = $clog2(NCYC + 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(NCYC - 1);

    // Reject parameter sets the datapath cannot represent.
    if (BPC < 1 || BPC > DATAWIDTH) begin : g_bad_bpc_range
        $error("crc_stream_engine: BPC must be in 1..DATAWIDTH");
    end
    if ((DATAWIDTH % BPC) != 0) begin : g_bad_bpc_div
        $error("crc_stream_engine: DATAWIDTH must be a multiple of BPC");
    end
    if (CRCWIDTH < 2 || CRCWIDTH > 32) begin : g_bad_crcwidth
        $error("crc_stream_engine: CRCWIDTH must be in 2..32");
    end
    if (DATAWIDTH < CRCWIDTH) begin : g_bad_datawidth
        $error("crc_stream_engine: DATAWIDTH must be at least CRCWIDTH");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t               state_q,     state_d;
    logic [CNTW-1:0]      cnt_q,       cnt_d;
    logic [CRCWIDTH-1:0]  crc_q,       crc_d;
    logic [DATAWIDTH-1:0] shift_q,     shift_d;
    logic [CRCWIDTH-1:0]  poly_q,      poly_d;
    logic [CRCWIDTH-1:0]  crcin_q,     crcin_d;
    logic                 mode_q,      mode_d;
    logic                 in_ready_q,  in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic [CRCWIDTH-1:0]  crc_seq_q,   crc_seq_d;
    logic                 crc_ok_q,    crc_ok_d;

    logic [CRCWIDTH-1:0]  crc_step;
    logic [DATAWIDTH-1:0] shift_step;
    logic                 fb;

    // The implicit x^CRCWIDTH term of the generator is never stored.
    logic unused_poly_msb;
    assign unused_poly_msb = bus.genPoly[CRCWIDTH];

    // BPC unrolled single-bit division steps. The shift register refills with
    // zeros, which supplies the CRCWIDTH augmenting zeros after the message.
    always_comb begin
        crc_step   = crc_q;
        shift_step = shift_q;
        fb         = 1'b0;
        for (int i = 0; i < BPC; i++) begin
            fb         = crc_step[CRCWIDTH-1];
            crc_step   = {crc_step[CRCWIDTH-2:0], shift_step[DATAWIDTH-1]}
                         ^ (fb ? poly_q : '0);
            shift_step = shift_step << 1;
        end
    end

    // Next-state and next-output logic for the IDLE -> SHIFT -> DONE sequence.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        crc_d       = crc_q;
        shift_d     = shift_q;
        poly_d      = poly_q;
        crcin_d     = crcin_q;
        mode_d      = mode_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        crc_seq_d   = crc_seq_q;
        crc_ok_d    = crc_ok_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    mode_d     = bus.mode;
                    crcin_d    = bus.crcin;
                    poly_d     = bus.genPoly[CRCWIDTH-1:0];
                    crc_d      = bus.datain[DATAWIDTH-1 -: CRCWIDTH] ^ INIT;
                    shift_d    = bus.datain << CRCWIDTH;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                crc_d   = crc_step;
                shift_d = shift_step;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                    crc_seq_d   = crc_step ^ XOROUT;
                    crc_ok_d    = mode_q & ((crc_step ^ XOROUT) == crcin_q);
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    // State and registered outputs; reset aborts any request in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            crc_q       <= '0;
            shift_q     <= '0;
            poly_q      <= '0;
            crcin_q     <= '0;
            mode_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            crc_seq_q   <= '0;
            crc_ok_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            crc_q       <= crc_d;
            shift_q     <= shift_d;
            poly_q      <= poly_d;
            crcin_q     <= crcin_d;
            mode_q      <= mode_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            crc_seq_q   <= crc_seq_d;
            crc_ok_q    <= crc_ok_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.crcSeq    = crc_seq_q;
    assign bus.crc_ok    = crc_ok_q;
endmodule
